irq_trap_seq: RTL and testbench

Sequences machine-mode interrupt entry and WFI sleep/wake for the core.
- Consumes the masked interrupt requests and cause from the interrupt-qualification logic.
- Picks a safe commit point, requests a pipeline flush, then issues a one-cycle trap commit (mepc/mcause write, PC redirect).
- Owns the WFI flag and the sleep/clock-gate request. Sits between the interrupt-qualification unit, the commit stage, and the CSR/PC-redirect logic.

---
 rtl/irq_trap_seq_pkg.sv | 24 ++
 rtl/irq_vec_calc.sv | 27 ++
 rtl/irq_trap_seq.sv | 124 ++++++++++++
 tb/tb_irq_trap_seq.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_trap_seq_pkg.sv
// irq_trap_seq_pkg: shared types and constants for the interrupt/WFI sequencer.
//   XLEN_DEF    - default data/address width
//   state_t     - sequencer state encoding
//   WAKE_CNT_W  - width of the post-sleep settle counter
//   is_vectored - decodes the mtvec mode field
package irq_trap_seq_pkg;

  localparam int unsigned XLEN_DEF   = 32;
  localparam int unsigned WAKE_CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARB   = 3'd1,
    ST_FLUSH = 3'd2,
    ST_TRAP  = 3'd3,
    ST_SLEEP = 3'd4,
    ST_WAKE  = 3'd5
  } state_t;

  function automatic logic is_vectored(input logic [1:0] mode);
    return (mode == 2'b01);
  endfunction

endpackage

// File: rtl/irq_vec_calc.sv
// irq_vec_calc: combinational trap redirect target.
//   mtvec    in  XLEN  current mtvec CSR
//   cause_lo in  4     low bits of the latched mcause
//   trap_pc  out XLEN  base (direct) or base + 4*cause (vectored)
module irq_vec_calc
  import irq_trap_seq_pkg::*;
#(
  parameter int unsigned XLEN    = XLEN_DEF,
  parameter bit          VECT_EN = 1'b1
) (
  input  logic [XLEN-1:0] mtvec,
  input  logic [3:0]      cause_lo,
  output logic [XLEN-1:0] trap_pc
);

  logic [XLEN-1:0] base;
  logic [XLEN-1:0] offset;

  always_comb begin
    base        = {mtvec[XLEN-1:2], 2'b00};
    offset      = '0;
    offset[5:0] = {cause_lo, 2'b00};
    // Sum wraps modulo 2^XLEN.
    trap_pc     = (VECT_EN && is_vectored(mtvec[1:0])) ? (base + offset) : base;
  end

endmodule

// File: rtl/irq_trap_seq.sv
// irq_trap_seq: machine-mode interrupt entry and WFI sleep/wake sequencer.
//   clk, rst                     clock, async active-high reset
//   dbg_mode                     core in debug mode (blocks entry, forces wake)
//   irq_req / wfi_irq_req        masked / MIE-ignoring interrupt pending
//   irq_cause                    mcause for the pending interrupt
//   cmt_vld/cmt_pc/cmt_is_jump/cmt_is_wfi  commit stage view
//   excp_busy                    synchronous exception in progress
//   flush_ack, mtvec             flush handshake, trap vector CSR
//   wfi_flag_r, sleep_req        WFI status and clock-gate request
//   irq_busy, flush_req          fetch/issue stall, flush request
//   trap_vld/trap_mepc/trap_mcause/trap_pc  one-cycle trap commit
module irq_trap_seq
  import irq_trap_seq_pkg::*;
#(
  parameter int unsigned XLEN        = XLEN_DEF,
  parameter int unsigned VECT_EN     = 1,
  parameter int unsigned WAKE_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dbg_mode,
  input  logic            irq_req,
  input  logic            wfi_irq_req,
  input  logic [XLEN-1:0] irq_cause,
  input  logic            cmt_vld,
  input  logic [XLEN-1:0] cmt_pc,
  input  logic            cmt_is_jump,
  input  logic            cmt_is_wfi,
  input  logic            excp_busy,
  input  logic            flush_ack,
  input  logic [XLEN-1:0] mtvec,
  output logic            wfi_flag_r,
  output logic            sleep_req,
  output logic            irq_busy,
  output logic            flush_req,
  output logic            trap_vld,
  output logic [XLEN-1:0] trap_mepc,
  output logic [XLEN-1:0] trap_mcause,
  output logic [XLEN-1:0] trap_pc
);

  localparam logic [WAKE_CNT_W-1:0] WAKE_INIT = WAKE_CNT_W'(WAKE_CYCLES);

  state_t                state;
  state_t                state_nxt;
  logic [WAKE_CNT_W-1:0] wake_cnt;
  logic                  latch_en;
  logic                  wake_load;

  always_comb begin
    state_nxt = state;
    latch_en  = 1'b0;
    wake_load = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!excp_busy) begin
          if (irq_req && !dbg_mode)                     state_nxt = ST_ARB;
          else if (cmt_vld && cmt_is_wfi && !dbg_mode)  state_nxt = ST_SLEEP;
        end
      end
      ST_ARB: begin
        if (!irq_req || dbg_mode) begin
          state_nxt = ST_IDLE;
        end else if (cmt_vld && !cmt_is_jump && !excp_busy) begin
          latch_en  = 1'b1;
          state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: if (flush_ack) state_nxt = ST_TRAP;
      ST_TRAP:  state_nxt = ST_IDLE;
      ST_SLEEP: begin
        if (wfi_irq_req || dbg_mode) begin
          wake_load = 1'b1;
          state_nxt = ST_WAKE;
        end
      end
      ST_WAKE: begin
        if (wake_cnt == WAKE_CNT_W'(1))
          state_nxt = (irq_req && !dbg_mode) ? ST_ARB : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up
  // with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      wake_cnt    <= '0;
      trap_mepc   <= '0;
      trap_mcause <= '0;
      irq_busy    <= 1'b0;
      sleep_req   <= 1'b0;
      wfi_flag_r  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (latch_en) begin
        trap_mepc   <= cmt_pc;
        trap_mcause <= irq_cause;
      end
      if (wake_load)
        wake_cnt <= WAKE_INIT;
      else if (state == ST_WAKE && wake_cnt != '0)
        wake_cnt <= wake_cnt - WAKE_CNT_W'(1);
      irq_busy   <= (state_nxt != ST_IDLE);
      sleep_req  <= (state_nxt == ST_SLEEP);
      wfi_flag_r <= (state_nxt == ST_SLEEP) || (state_nxt == ST_WAKE);
    end
  end

  assign flush_req = (state == ST_FLUSH);
  assign trap_vld  = (state == ST_TRAP);

  irq_vec_calc #(
    .XLEN    (XLEN),
    .VECT_EN (VECT_EN != 0)
  ) u_vec_calc (
    .mtvec    (mtvec),
    .cause_lo (trap_mcause[3:0]),
    .trap_pc  (trap_pc)
  );

endmodule

// File: tb/tb_irq_trap_seq.sv
module tb_irq_trap_seq;

  localparam int WAKE_N = 2;
  localparam bit VECT   = 1'b1;

  logic        clk = 1'b0;
  logic        rst;
  logic        dbg_mode, irq_req, wfi_irq_req;
  logic [31:0] irq_cause;
  logic        cmt_vld;
  logic [31:0] cmt_pc;
  logic        cmt_is_jump, cmt_is_wfi, excp_busy, flush_ack;
  logic [31:0] mtvec;
  logic        wfi_flag_r, sleep_req, irq_busy, flush_req, trap_vld;
  logic [31:0] trap_mepc, trap_mcause, trap_pc;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  irq_trap_seq #(
    .XLEN        (32),
    .VECT_EN     (1),
    .WAKE_CYCLES (WAKE_N)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .dbg_mode    (dbg_mode),
    .irq_req     (irq_req),
    .wfi_irq_req (wfi_irq_req),
    .irq_cause   (irq_cause),
    .cmt_vld     (cmt_vld),
    .cmt_pc      (cmt_pc),
    .cmt_is_jump (cmt_is_jump),
    .cmt_is_wfi  (cmt_is_wfi),
    .excp_busy   (excp_busy),
    .flush_ack   (flush_ack),
    .mtvec       (mtvec),
    .wfi_flag_r  (wfi_flag_r),
    .sleep_req   (sleep_req),
    .irq_busy    (irq_busy),
    .flush_req   (flush_req),
    .trap_vld    (trap_vld),
    .trap_mepc   (trap_mepc),
    .trap_mcause (trap_mcause),
    .trap_pc     (trap_pc)
  );

  // Reference model: what the sequencer is doing right now, in plain terms.
  localparam int M_IDLE = 0, M_ARB = 1, M_FLUSH = 2, M_TRAP = 3, M_SLEEP = 4, M_WAKE = 5;
  int          m_phase;
  int          m_wake_left;
  logic [31:0] m_mepc, m_mcause;

  task automatic model_reset();
    m_phase     = M_IDLE;
    m_wake_left = 0;
    m_mepc      = 0;
    m_mcause    = 0;
  endtask

  task automatic model_step();
    if (rst) begin
      model_reset();
    end else begin
      case (m_phase)
        M_IDLE:
          if (!excp_busy) begin
            if (irq_req && !dbg_mode) m_phase = M_ARB;
            else if (cmt_vld && cmt_is_wfi && !dbg_mode) m_phase = M_SLEEP;
          end
        M_ARB:
          if (!irq_req || dbg_mode) m_phase = M_IDLE;
          else if (cmt_vld && !cmt_is_jump && !excp_busy) begin
            m_mepc   = cmt_pc;
            m_mcause = irq_cause;
            m_phase  = M_FLUSH;
          end
        M_FLUSH: if (flush_ack) m_phase = M_TRAP;
        M_TRAP:  m_phase = M_IDLE;
        M_SLEEP:
          if (wfi_irq_req || dbg_mode) begin
            m_phase     = M_WAKE;
            m_wake_left = WAKE_N;
          end
        M_WAKE: begin
          m_wake_left = m_wake_left - 1;
          if (m_wake_left == 0) m_phase = (irq_req && !dbg_mode) ? M_ARB : M_IDLE;
        end
        default: m_phase = M_IDLE;
      endcase
    end
  endtask

  function automatic logic [31:0] model_pc();
    logic [31:0] base;
    base = mtvec & 32'hFFFF_FFFC;
    if (VECT && (mtvec % 4 == 1)) return base + 32'(4 * (m_mcause % 16));
    return base;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic compare_all();
    chk("irq_busy",    32'(irq_busy),   32'(m_phase != M_IDLE));
    chk("flush_req",   32'(flush_req),  32'(m_phase == M_FLUSH));
    chk("trap_vld",    32'(trap_vld),   32'(m_phase == M_TRAP));
    chk("sleep_req",   32'(sleep_req),  32'(m_phase == M_SLEEP));
    chk("wfi_flag_r",  32'(wfi_flag_r), 32'(m_phase == M_SLEEP || m_phase == M_WAKE));
    chk("trap_mepc",   trap_mepc,   m_mepc);
    chk("trap_mcause", trap_mcause, m_mcause);
    chk("trap_pc",     trap_pc,     model_pc());
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    dbg_mode = 0; irq_req = 0; wfi_irq_req = 0; irq_cause = 0;
    cmt_vld = 0; cmt_pc = 0; cmt_is_jump = 0; cmt_is_wfi = 0;
    excp_busy = 0; flush_ack = 0;
  endtask

  // Assert reset between edges and confirm outputs drop without a clock.
  task automatic async_rst(input string name);
    #2;
    rst = 1;
    #1;
    model_reset();
    chk({name, "_busy"},  32'(irq_busy),  0);
    chk({name, "_sleep"}, 32'(sleep_req), 0);
    chk({name, "_flush"}, 32'(flush_req), 0);
    chk({name, "_wfi"},   32'(wfi_flag_r), 0);
    compare_all();
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  initial begin
    logic [31:0] r;
    idle_inputs();
    mtvec = 32'h0000_1001;
    rst   = 1;
    #12;
    model_reset();
    chk("rst_busy", 32'(irq_busy), 0);
    chk("rst_mepc", trap_mepc, 0);
    compare_all();
    @(posedge clk); #1;
    rst = 0;

    // Timer interrupt, vectored.
    irq_req = 1; irq_cause = 32'h8000_0007; cmt_vld = 1; cmt_pc = 32'h200;
    cycle();
    chk("t1_arb_busy", 32'(irq_busy), 1);
    cycle();
    chk("t1_flush", 32'(flush_req), 1);
    chk("t1_mepc", trap_mepc, 32'h200);
    flush_ack = 1;
    cycle();
    chk("t1_trap_vld", 32'(trap_vld), 1);
    chk("t1_mcause", trap_mcause, 32'h8000_0007);
    chk("t1_pc", trap_pc, 32'h0000_101C);
    irq_req = 0; flush_ack = 0;
    cycle();
    chk("t1_trap_one", 32'(trap_vld), 0);

    // Direct mode, then entry delayed by jump commits.
    mtvec = 32'h0000_1000;
    #1;
    chk("t2_pc_direct", trap_pc, 32'h0000_1000);
    irq_req = 1; cmt_is_jump = 1; cmt_pc = 32'h300;
    cycle();
    cmt_pc = 32'h304;
    cycle();
    chk("t2_jump_hold", 32'(flush_req), 0);
    cmt_pc = 32'h308;
    cycle();
    cmt_is_jump = 0; cmt_pc = 32'h30C;
    cycle();
    chk("t2_mepc", trap_mepc, 32'h30C);
    flush_ack = 1;
    cycle();
    chk("t2_trap_pc", trap_pc, 32'h0000_1000);
    idle_inputs();
    cycle();

    // WFI with MIE=0 wake.
    cmt_vld = 1; cmt_is_wfi = 1; cmt_pc = 32'h400;
    cycle();
    chk("t3_sleep", 32'(sleep_req), 1);
    chk("t3_wfi", 32'(wfi_flag_r), 1);
    cmt_vld = 0; cmt_is_wfi = 0;
    cycle();
    wfi_irq_req = 1;
    cycle();
    chk("t3_wake_sleep", 32'(sleep_req), 0);
    chk("t3_wake_wfi", 32'(wfi_flag_r), 1);
    wfi_irq_req = 0;
    cycle();
    cycle();
    chk("t3_idle", 32'(irq_busy), 0);

    // WFI then external interrupt with MIE=1.
    cmt_vld = 1; cmt_is_wfi = 1;
    cycle();
    cmt_is_wfi = 0; cmt_pc = 32'h404;
    wfi_irq_req = 1; irq_req = 1; irq_cause = 32'h8000_000B; flush_ack = 1;
    repeat (4) cycle();
    cycle();
    chk("t4_trap", 32'(trap_vld), 1);
    chk("t4_mcause", trap_mcause, 32'h8000_000B);
    chk("t4_mepc", trap_mepc, 32'h404);
    idle_inputs();
    cycle();

    // Abort in ARB, debug blocking, WFI in debug.
    irq_req = 1;
    cycle();
    irq_req = 0;
    cycle();
    chk("t5_abort", 32'(irq_busy), 0);
    dbg_mode = 1; irq_req = 1;
    cycle();
    chk("t5_dbg", 32'(irq_busy), 0);
    irq_req = 0; cmt_vld = 1; cmt_is_wfi = 1;
    cycle();
    chk("t5_dbg_wfi", 32'(sleep_req), 0);
    idle_inputs();

    // Reset mid-FLUSH and mid-SLEEP.
    irq_req = 1; cmt_vld = 1; cmt_pc = 32'h500;
    cycle(); cycle();
    chk("t6_in_flush", 32'(flush_req), 1);
    irq_req = 0;
    async_rst("t6_flush_rst");
    cycle();
    cmt_is_wfi = 1;
    cycle();
    chk("t6_in_sleep", 32'(sleep_req), 1);
    cmt_is_wfi = 0; cmt_vld = 0;
    async_rst("t6_sleep_rst");
    cycle();

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      r = $urandom;
      if (r[2:0] == 3'd0) irq_req = ~irq_req;
      dbg_mode    = ($urandom_range(0, 99) < 4);
      wfi_irq_req = ($urandom_range(0, 99) < 20);
      cmt_vld     = ($urandom_range(0, 99) < 70);
      cmt_is_jump = ($urandom_range(0, 99) < 25);
      cmt_is_wfi  = ($urandom_range(0, 99) < 10);
      excp_busy   = ($urandom_range(0, 99) < 10);
      flush_ack   = ($urandom_range(0, 99) < 40);
      r = $urandom;
      cmt_pc = {r[31:2], 2'b00};
      r = $urandom;
      irq_cause = {1'b1, 27'd0, r[3:0]};
      if (n % 50 == 0) begin
        r = $urandom;
        mtvec = {r[31:2], 1'b0, r[0]};
      end
      if ($urandom_range(0, 399) == 0) async_rst("rand_rst");
      else cycle();
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
